// File: rtl/core_pkg.sv
// Shared types and constants for the ID-stage hazard sequencer.
package core_pkg;

  typedef enum logic [0:0] {RUN, BUBBLE} ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Bubbles owed beyond the detect cycle, which is always the first bubble.
  localparam logic [1:0] BUB_ONE = 2'd0;
  localparam logic [1:0] BUB_TWO = 2'd1;

  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic use_rs1,
                                     input logic use_rs2);
    return (rd != REG_X0) && (((rd == rs1) && use_rs1) || ((rd == rs2) && use_rs2));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Control bundle between the ID-stage hazard sequencer and the pipeline registers.
interface id_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             id_ex_regwrite;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic             ex_mem_memread;
  logic [4:0]       ex_mem_rd;
  logic             im_stall;
  logic             dm_stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_write;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] freeze_cycles;
  logic             freeze_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_branch_taken,
           id_ex_regwrite, id_ex_memread, id_ex_rd, ex_mem_memread, ex_mem_rd,
           im_stall, dm_stall,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write,
           stall_cycles, freeze_cycles, freeze_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_branch_taken,
           id_ex_regwrite, id_ex_memread, id_ex_rd, ex_mem_memread, ex_mem_rd,
           im_stall, dm_stall,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write,
           stall_cycles, freeze_cycles, freeze_timeout
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard classification for the instruction in ID: one or two bubbles.
module hazard_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       id_is_branch_i,
  input  logic       id_ex_regwrite_i,
  input  logic       id_ex_memread_i,
  input  logic [4:0] id_ex_rd_i,
  input  logic       ex_mem_memread_i,
  input  logic [4:0] ex_mem_rd_i,
  output logic       need1_o,
  output logic       need2_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(id_ex_rd_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i);
  assign mem_hit = reg_match(ex_mem_rd_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i);

  assign need2_o = id_is_branch_i & id_ex_memread_i & ex_hit;
  assign need1_o = ~need2_o & ((id_ex_memread_i & ex_hit) |
                               (id_is_branch_i & id_ex_regwrite_i & ex_hit) |
                               (id_is_branch_i & ex_mem_memread_i & mem_hit));

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage stall sequencer: hazard bubbles, memory freeze, branch flush, stall
// statistics and a freeze watchdog.
module id_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FREEZE_LIMIT = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input logic             clk,
  input logic             rst_n,
  id_hazard_ctrl_if.slave bus
);

  localparam int unsigned     RunW   = $clog2(FREEZE_LIMIT) + 1;
  localparam logic [RunW-1:0] RunMax = RunW'(FREEZE_LIMIT);

  ctrl_state_e      state_q, state_d;
  logic [1:0]       bub_cnt_q, bub_cnt_d;
  logic [1:0]       extra;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] frz_q, frz_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             timeout_q, timeout_d;
  logic             need1, need2, freeze, stalling;

  hazard_detect u_detect (
    .id_rs1_i         (bus.id_rs1),
    .id_rs2_i         (bus.id_rs2),
    .id_use_rs1_i     (bus.id_use_rs1),
    .id_use_rs2_i     (bus.id_use_rs2),
    .id_is_branch_i   (bus.id_is_branch),
    .id_ex_regwrite_i (bus.id_ex_regwrite),
    .id_ex_memread_i  (bus.id_ex_memread),
    .id_ex_rd_i       (bus.id_ex_rd),
    .ex_mem_memread_i (bus.ex_mem_memread),
    .ex_mem_rd_i      (bus.ex_mem_rd),
    .need1_o          (need1),
    .need2_o          (need2)
  );

  assign freeze   = bus.im_stall | bus.dm_stall;
  assign stalling = ~freeze & ((state_q == BUBBLE) | ((state_q == RUN) & (need1 | need2)));

  // The detect cycle in RUN is the first bubble; BUBBLE only supplies the extras.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    extra     = need2 ? BUB_TWO : BUB_ONE;
    if (!freeze) begin
      if (state_q == BUBBLE) begin
        if (bub_cnt_q == 2'd0) state_d = RUN;
        else                   bub_cnt_d = bub_cnt_q - 2'd1;
      end else if ((need1 | need2) && (extra != 2'd0)) begin
        state_d   = BUBBLE;
        bub_cnt_d = extra - 2'd1;
      end
    end
  end

  always_comb begin
    stall_d   = stalling ? stall_q + CNT_W'(1) : stall_q;
    frz_d     = freeze ? frz_q + CNT_W'(1) : frz_q;
    run_d     = !freeze ? '0 : ((run_q == RunMax) ? run_q : run_q + RunW'(1));
    timeout_d = timeout_q | (run_d == RunMax);
  end

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = bus.id_branch_taken;
    bus.id_ex_bubble = 1'b0;
    bus.pipe_write   = 1'b1;
    if (!rst_n) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      bus.pipe_write   = 1'b0;
    end else if (freeze) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.pipe_write   = 1'b0;
    end else if (stalling) begin
      // Branch operands are stale during a bubble, so the redirect is ignored.
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end
  end

  assign bus.stall_cycles   = stall_q;
  assign bus.freeze_cycles  = frz_q;
  assign bus.freeze_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      bub_cnt_q <= 2'd0;
      stall_q   <= '0;
      frz_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
      stall_q   <= stall_d;
      frz_q     <= frz_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
